mem_access_ctrl: RTL and testbench

//  Sequences a single load/store between the CPU memory stage and the

---
 rtl/mem_access_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU memory stage and a word-wide data memory.
// One access in flight; handles lane steering, load extension, misalignment and ack timeout.
package common_params;
  localparam int unsigned BITS           = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    BYTE,
    HALFWORD,
    WORD,
    UBYTE,
    UHALFWORD,
    LWCP
  } mem_data_t;
endpackage

// Sign/zero extension of a right-justified load value by access type.
module extender #(
  parameter int unsigned BITS = common_params::BITS
) (
  input  logic [BITS-1:0]         din,
  input  common_params::mem_data_t dtype,
  output logic [BITS-1:0]         dout
);
  always_comb begin
    dout = din;
    case (dtype)
      common_params::BYTE:      dout = {{(BITS-8){din[7]}}, din[7:0]};
      common_params::UBYTE:     dout = {{(BITS-8){1'b0}}, din[7:0]};
      common_params::HALFWORD:  dout = {{(BITS-16){din[15]}}, din[15:0]};
      common_params::UHALFWORD: dout = {{(BITS-16){1'b0}}, din[15:0]};
      default:                  dout = din;
    endcase
  end
endmodule

module mem_access_ctrl #(
  parameter int unsigned BITS           = common_params::BITS,
  parameter int unsigned BYTES_PER_WORD = common_params::BYTES_PER_WORD,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  common_params::mem_data_t      req_type,
  input  logic [BITS-1:0]               req_wdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-3:0]             mem_addr,
  output logic [BYTES_PER_WORD-1:0]     mem_be,
  output logic [BITS-1:0]               mem_wdata,
  input  logic [BITS-1:0]               mem_rdata,
  input  logic                          mem_ack,
  output logic                          rsp_valid,
  output logic [BITS-1:0]               rsp_rdata,
  output logic                          rsp_misalign,
  output logic                          rsp_timeout
);
  localparam int unsigned OFF_W    = $clog2(BYTES_PER_WORD);
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     we_q;
  logic [ADDR_W-1:0]        addr_q;
  common_params::mem_data_t type_q;
  logic [BITS-1:0]          wdata_q;
  logic [7:0]               cnt_q;
  logic [BITS-1:0]          rdata_q;
  logic                     misalign_q, timeout_q;

  logic                     accept, misalign_in, abort;
  logic [OFF_W-1:0]         off_in, off_q;
  logic [BYTES_PER_WORD-1:0] store_be;
  logic [BITS-1:0]          store_data, aligned, load_data;

  assign accept = req_valid && (state_q == IDLE);
  assign off_in = req_addr[OFF_W-1:0];
  assign off_q  = addr_q[OFF_W-1:0];
  assign abort  = (state_q == ACCESS) && !mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    misalign_in = 1'b0;
    case (req_type)
      common_params::BYTE, common_params::UBYTE:         misalign_in = 1'b0;
      common_params::HALFWORD, common_params::UHALFWORD: misalign_in = off_in[0];
      default:                                           misalign_in = (off_in != '0);
    endcase
  end

  always_comb begin
    store_be   = '1;
    store_data = wdata_q;
    case (type_q)
      common_params::BYTE, common_params::UBYTE: begin
        store_be   = BYTES_PER_WORD'(1) << off_q;
        store_data = BITS'(wdata_q[7:0]) << {off_q, 3'b000};
      end
      common_params::HALFWORD, common_params::UHALFWORD: begin
        store_be   = BYTES_PER_WORD'(3) << off_q;
        store_data = BITS'(wdata_q[15:0]) << {off_q, 3'b000};
      end
      default: begin
        store_be   = '1;
        store_data = wdata_q;
      end
    endcase
  end

  assign aligned = mem_rdata >> {off_q, 3'b000};

  extender #(.BITS(BITS)) u_ext (
    .din   (aligned),
    .dtype (type_q),
    .dout  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misalign_in ? RESP : ACCESS;
      ACCESS:  if (mem_ack || abort) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q[ADDR_W-1:OFF_W];
      mem_be    = we_q ? store_be : '1;
      mem_wdata = we_q ? store_data : '0;
    end
  end

  // Response registers are only non-zero during RESP, so they need no output gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      type_q     <= common_params::BYTE;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        type_q  <= req_type;
        wdata_q <= req_wdata;
      end
      case (state_q)
        IDLE: begin
          cnt_q      <= '0;
          rdata_q    <= '0;
          timeout_q  <= 1'b0;
          misalign_q <= accept && misalign_in;
        end
        ACCESS: begin
          if (!mem_ack) cnt_q <= cnt_q + 8'd1;
          if (mem_ack && !we_q) rdata_q <= load_data;
          timeout_q <= abort;
        end
        default: begin
          rdata_q    <= '0;
          misalign_q <= 1'b0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_rdata    = rdata_q;
  assign rsp_misalign = misalign_q;
  assign rsp_timeout  = timeout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-lane reference model, random and corner-case accesses.
module tb_mem_access_ctrl;
  import common_params::*;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  mem_data_t   req_type;
  logic [31:0] req_wdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rsp_valid, rsp_misalign, rsp_timeout;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_r;

  mem_access_ctrl #(.ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_type     (req_type),
    .req_wdata    (req_wdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign),
    .rsp_timeout  (rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input mem_data_t t);
    case (t)
      BYTE, UBYTE:         return 1;
      HALFWORD, UHALFWORD: return 2;
      default:             return 4;
    endcase
  endfunction

  // Gather size bytes starting at the byte offset, then interpret as signed if required.
  function automatic logic [31:0] load_model(input logic [31:0] rd, input int off, input mem_data_t t);
    longint v;
    int     sz;
    sz = size_of(t);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v + (longint'(rd[8*(off+i) +: 8]) << (8*i));
    if ((t == BYTE || t == HALFWORD) && v >= (longint'(1) << (8*sz - 1)))
      v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected actual=rsp_valid required=no_response at %0t", $time);
      end else begin
        exp_r = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp_r.rdata);
        check("rsp_misalign", 32'(rsp_misalign), 32'(exp_r.mis));
        check("rsp_timeout", 32'(rsp_timeout), 32'(exp_r.to));
      end
    end
  end

  // delay < 0 means the memory never acknowledges.
  task automatic do_req(input bit we, input logic [15:0] addr, input mem_data_t t,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay);
    rsp_t        e;
    int          sz, off, n;
    bit          mis;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    sz  = size_of(t);
    off = int'(addr % 4);
    mis = (int'(addr) % sz) != 0;
    ebe = '0;
    ewd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) begin
        ebe[i]       = 1'b1;
        ewd[8*i +: 8] = wd[8*(i-off) +: 8];
      end
    end
    e.mis   = mis;
    e.to    = !mis && delay < 0;
    e.rdata = (mis || we || delay < 0) ? 32'h0 : load_model(rd, off, t);

    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_wait", 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_type  = t;
    req_wdata = wd;
    mem_ack   = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_type  = mem_data_t'($urandom_range(0, 5));
    req_wdata = $urandom;

    if (!mis) begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        @(negedge clk);
        check("mem_en_access", 32'(mem_en), 32'h1);
        check("req_ready_busy", 32'(req_ready), 32'h0);
        check("rsp_valid_busy", 32'(rsp_valid), 32'h0);
        check("mem_we", 32'(mem_we), 32'(we));
        check("mem_addr", 32'(mem_addr), 32'(addr >> 2));
        check("mem_be", 32'(mem_be), 32'(we ? ebe : 4'hF));
        if (we) check("mem_wdata", mem_wdata, ewd);
        if (k == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (k == delay) break;
      end
    end
    @(negedge clk);
    check("rsp_valid_latency", 32'(rsp_valid), 32'h1);
    check("mem_en_after", 32'(mem_en), 32'h0);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_type  = BYTE;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    #3;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_mem_be", 32'(mem_be), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 16'h0003, BYTE,      32'h0, 32'h80AA55CC, 0);
    do_req(1'b0, 16'h0003, UBYTE,     32'h0, 32'h80AA55CC, 0);
    do_req(1'b1, 16'h0002, HALFWORD,  32'h1234BEEF, 32'h0, 2);
    do_req(1'b0, 16'h0006, WORD,      32'h0, 32'h12345678, 0);
    do_req(1'b0, 16'h0005, HALFWORD,  32'h0, 32'h12345678, 0);
    do_req(1'b0, 16'h0002, UHALFWORD, 32'h0, 32'hF00D0000, 5);
    do_req(1'b0, 16'h0100, WORD,      32'h0, 32'hDEADBEEF, -1);
    do_req(1'b0, 16'h0104, WORD,      32'h0, 32'hCAFEF00D, int'(TIMEOUT) - 1);
    do_req(1'b1, 16'h0041, UBYTE,     32'hFFFFFFA5, 32'h0, 1);
    do_req(1'b0, 16'h0008, LWCP,      32'h0, 32'h8000_0001, 3);
    do_req(1'b1, 16'h0203, WORD,      32'h11223344, 32'h0, 0);

    // Reset asserted in the middle of an access that is never acknowledged.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0010;
    req_type  = WORD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_mem_en", 32'(mem_en), 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_mem_en", 32'(mem_en), 32'h0);
    check("rst_async_req_ready", 32'(req_ready), 32'h1);
    check("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 250; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      do_req(1'($urandom), 16'($urandom), mem_data_t'($urandom_range(0, 5)), $urandom, $urandom, d);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
